// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
//   Round-robin arbiter that shares the write port of one fifo among four
//   producers. A producer is granted for a burst of up to BURST_LEN
//   transfers. While it holds the grant, its data and rts/rtr handshake are
//   steered onto the fifo input. The arbiter holds no data, so words from
//   one producer reach the fifo in the order that producer sent them.
//
//   Optional feature (macro FIFO_ARB_TAG_EN):
//     defined   : out_data = {grant_id, payload}, DATA_WIDTH+2 bits
//     undefined : out_data = payload only, DATA_WIDTH bits
//
// Ports
//   clk          clock; all state changes on the rising edge
//   rst          asynchronous active-high reset
//   req_data     producer data, requester i in [i*DATA_WIDTH +: DATA_WIDTH]
//   req_rts      per-requester ready-to-send
//   req_rtr      per-requester ready-to-receive
//   req_xfc      per-requester transfer complete (req_rts & req_rtr)
//   out_data     to fifo in_data
//   out_rts      to fifo in_rts
//   out_rtr      from fifo in_rtr
//   out_xfc      out_rts & out_rtr
//   grant_valid  a grant is currently held
//   grant_id     index of the granted requester
//   burst_cnt    transfers completed in the current grant
module fifo_wr_arbiter #(
  parameter int DATA_WIDTH = 12,
  parameter int BURST_LEN  = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [4*DATA_WIDTH-1:0]   req_data,
  input  logic [3:0]                req_rts,
  output logic [3:0]                req_rtr,
  output logic [3:0]                req_xfc,
`ifdef FIFO_ARB_TAG_EN
  output logic [DATA_WIDTH+1:0]     out_data,
`else
  output logic [DATA_WIDTH-1:0]     out_data,
`endif
  output logic                      out_rts,
  input  logic                      out_rtr,
  output logic                      out_xfc,
  output logic                      grant_valid,
  output logic [1:0]                grant_id,
  output logic [7:0]                burst_cnt
);

  localparam logic [7:0] LAST_CNT = 8'(BURST_LEN - 1);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t          state, state_nxt;
  logic [1:0]      grant_id_nxt;
  logic [1:0]      last_id, last_id_nxt;
  logic [7:0]      burst_cnt_nxt;
  logic [DATA_WIDTH-1:0] sel_data;
  logic [2:0]      pick;
  logic            burst_end;

  // Returns {found, index}: the first requester with rts high, searching
  // from prev+1 upward and wrapping. prev itself is examined last, so a
  // requester whose burst just ended only wins if nobody else is asking.
  function automatic logic [2:0] rr_pick(input logic [3:0] rts,
                                         input logic [1:0] prev);
    logic [1:0] idx;
    rr_pick = 3'b000;
    // Walk from the farthest candidate to the nearest so the nearest
    // requesting one is the final assignment.
    for (int k = 4; k >= 1; k--) begin
      idx = prev + 2'(k);
      if (rts[idx]) rr_pick = {1'b1, idx};
    end
  endfunction

  // Combinational datapath steered by the registered grant
  assign grant_valid = (state == GRANT);
  assign sel_data    = req_data[int'(grant_id)*DATA_WIDTH +: DATA_WIDTH];
  assign out_rts     = grant_valid & req_rts[grant_id];
  assign out_xfc     = out_rts & out_rtr;
  assign req_rtr     = (grant_valid & out_rtr) ? (4'b0001 << grant_id) : 4'b0000;
  assign req_xfc     = req_rts & req_rtr;

`ifdef FIFO_ARB_TAG_EN
  assign out_data = grant_valid ? {grant_id, sel_data} : '0;
`else
  assign out_data = grant_valid ? sel_data : '0;
`endif

  // last_id equals grant_id during a grant, so one search base covers both
  // the IDLE pick and the end-of-burst re-pick.
  assign pick      = rr_pick(req_rts, last_id);
  assign burst_end = (out_xfc && (burst_cnt == LAST_CNT)) || !req_rts[grant_id];

  always_comb begin
    state_nxt     = state;
    grant_id_nxt  = grant_id;
    last_id_nxt   = last_id;
    burst_cnt_nxt = burst_cnt;
    case (state)
      IDLE: begin
        if (pick[2]) begin
          state_nxt     = GRANT;
          grant_id_nxt  = pick[1:0];
          last_id_nxt   = pick[1:0];
          burst_cnt_nxt = 8'd0;
        end
      end
      GRANT: begin
        if (burst_end) begin
          burst_cnt_nxt = 8'd0;
          if (pick[2]) begin
            grant_id_nxt = pick[1:0];
            last_id_nxt  = pick[1:0];
          end else begin
            state_nxt = IDLE;
          end
        end else if (out_xfc) begin
          burst_cnt_nxt = burst_cnt + 8'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      grant_id  <= 2'd0;
      last_id   <= 2'd3;
      burst_cnt <= 8'd0;
    end else begin
      state     <= state_nxt;
      grant_id  <= grant_id_nxt;
      last_id   <= last_id_nxt;
      burst_cnt <= burst_cnt_nxt;
    end
  end

endmodule
